// File: rtl/pipeline_run_ctrl.sv
// Run-control unit for the 5-stage MIPS pipeline.
// Generates the pipeline-wide valid enable in continuous or single-step mode,
// freezes fetch and drains the pipe when HALT leaves IF, and counts enabled cycles.
// Optional breakpoint support is compiled in with PIPELINE_RUN_CTRL_BREAKPOINT_EN.
module pipeline_run_ctrl #(
    parameter int                   NB_INSTR    = 32,
    parameter int                   NB_OPCODE   = 6,
    parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111,
    parameter int                   N_STAGES    = 5,
    parameter int                   NB_CNT      = 32
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic                i_mode,
    input  logic                i_step,
    input  logic                i_abort,
    input  logic [NB_INSTR-1:0] i_fetch_instr,
    output logic                o_valid,
    output logic                o_fetch_hold,
    output logic                o_busy,
    output logic                o_done,
    output logic [NB_CNT-1:0]   o_n_clocks
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    ,
    input  logic                i_bp_en,
    input  logic [31:0]         i_bp_pc,
    input  logic [31:0]         i_fetch_pc,
    output logic                o_break
`endif
);

    // Drain counter only has to hold N_STAGES-2
    localparam int NB_DRAIN = ($clog2(N_STAGES) < 1) ? 1 : $clog2(N_STAGES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP_WAIT,
        S_STEP,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic [NB_DRAIN-1:0] drain_cnt_nxt;
    logic                halt_op;
    logic                cnt_clear;

    // Saturating increment: the cycle counter sticks at all-ones instead of wrapping
    function automatic logic [NB_CNT-1:0] sat_inc(input logic [NB_CNT-1:0] v);
        return (&v) ? v : v + NB_CNT'(1);
    endfunction

    assign halt_op = (i_fetch_instr[NB_INSTR-1 -: NB_OPCODE] == HALT_OPCODE);

    // Outputs are decoded straight from the state register (Moore)
    assign o_valid      = (state == S_RUN) || (state == S_STEP) || (state == S_DRAIN);
    assign o_fetch_hold = (state == S_DRAIN);
    assign o_busy       = (state != S_IDLE);
    assign o_done       = (state == S_DONE);

    // A start that is overridden by abort must not clear the count either
    assign cnt_clear = (state == S_IDLE) && i_start && !i_abort;

`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    logic bp_hit;
    logic break_nxt;
    assign bp_hit = i_bp_en && (i_fetch_pc == i_bp_pc);
`endif

    // Next-state logic; abort is applied last so it beats step, HALT and breakpoint
    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
        break_nxt     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (i_start) state_nxt = i_mode ? S_STEP_WAIT : S_RUN;
            end
            S_RUN: begin
                if (halt_op) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = NB_DRAIN'(N_STAGES - 2);
                end
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
                else if (bp_hit) begin
                    state_nxt = S_STEP_WAIT;
                    break_nxt = 1'b1;
                end
`endif
            end
            S_STEP_WAIT: begin
                if (i_step) state_nxt = S_STEP;
            end
            S_STEP: begin
                if (halt_op) begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = NB_DRAIN'(N_STAGES - 2);
                end else begin
                    state_nxt = S_STEP_WAIT;
                end
            end
            S_DRAIN: begin
                if (drain_cnt == '0) state_nxt = S_DONE;
                else                 drain_cnt_nxt = drain_cnt - NB_DRAIN'(1);
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (i_abort) begin
            state_nxt     = S_IDLE;
            drain_cnt_nxt = '0;
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
            break_nxt     = 1'b0;
`endif
        end
    end

    // State and drain counter registers
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    // Enabled-cycle counter: cleared on an accepted start, held while idle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset)        o_n_clocks <= '0;
        else if (cnt_clear) o_n_clocks <= '0;
        else if (o_valid)   o_n_clocks <= sat_inc(o_n_clocks);
    end

`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    // One-cycle breakpoint pulse, coincident with the first STEP_WAIT cycle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) o_break <= 1'b0;
        else         o_break <= break_nxt;
    end
`endif

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Testbench for pipeline_run_ctrl: randomized scenarios checked against a
// timeline model built from the run-control rules (valid windows, drain length,
// done cycle, counter = number of valid cycles so far). A second instance with
// a 4-bit counter shares the same stimulus to observe saturation.
module tb_pipeline_run_ctrl;

    localparam int          NS   = 5;
    localparam logic [5:0]  HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, step = 1'b0, abort = 1'b0;
    logic [31:0] instr = '0;
    logic        valid, hold, busy, done;
    logic [31:0] ncnt;
    logic        valid_s, hold_s, busy_s, done_s;
    logic [3:0]  ncnt_s;
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    logic        bp_en = 1'b0;
    logic [31:0] bp_pc = '0, fetch_pc = '0;
    logic        brk, brk_s;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipeline_run_ctrl #(.NB_INSTR(32), .NB_OPCODE(6), .HALT_OPCODE(HALT), .N_STAGES(NS), .NB_CNT(32)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .i_abort(abort), .i_fetch_instr(instr), .o_valid(valid), .o_fetch_hold(hold),
        .o_busy(busy), .o_done(done), .o_n_clocks(ncnt)
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
        , .i_bp_en(bp_en), .i_bp_pc(bp_pc), .i_fetch_pc(fetch_pc), .o_break(brk)
`endif
    );

    pipeline_run_ctrl #(.NB_INSTR(32), .NB_OPCODE(6), .HALT_OPCODE(HALT), .N_STAGES(NS), .NB_CNT(4)) dut_sat (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .i_abort(abort), .i_fetch_instr(instr), .o_valid(valid_s), .o_fetch_hold(hold_s),
        .o_busy(busy_s), .o_done(done_s), .o_n_clocks(ncnt_s)
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
        , .i_bp_en(bp_en), .i_bp_pc(bp_pc), .i_fetch_pc(fetch_pc), .o_break(brk_s)
`endif
    );

    function automatic logic [31:0] word(input bit is_halt);
        logic [5:0] op;
        op = is_halt ? HALT : 6'($urandom_range(0, 62));
        return {op, 26'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", valid); end
        n_tests++; if (hold !== 1'b0) begin n_fail++; $display("FAIL rst_hold got=%b exp=0", hold); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
        n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%b exp=0", done); end
        n_tests++; if (ncnt !== 32'd0) begin n_fail++; $display("FAIL rst_cnt got=%0d exp=0", ncnt); end
        n_tests++; if (ncnt_s !== 4'd0) begin n_fail++; $display("FAIL rst_cnt_sat got=%0d exp=0", ncnt_s); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    endtask

    // Continuous run, HALT seen in RUN cycle h (h >= 1); spurious start/step/HALT where they must be ignored
    task automatic test_continuous(input int h);
        logic ev, eh, eb, ed;
        int   ec;
        for (int c = 0; c <= h + NS + 2; c++) begin
            if (c > 0) begin
                ev = (c <= h + NS - 1);
                eh = (c > h) && (c <= h + NS - 1);
                ed = (c == h + NS);
                eb = (c <= h + NS);
                ec = (c - 1 < h + NS - 1) ? c - 1 : h + NS - 1;
                n_tests++; if (valid !== ev) begin n_fail++; $display("FAIL cont_valid h=%0d cyc=%0d got=%b exp=%b", h, c, valid, ev); end
                n_tests++; if (hold !== eh) begin n_fail++; $display("FAIL cont_hold h=%0d cyc=%0d got=%b exp=%b", h, c, hold, eh); end
                n_tests++; if (done !== ed) begin n_fail++; $display("FAIL cont_done h=%0d cyc=%0d got=%b exp=%b", h, c, done, ed); end
                n_tests++; if (busy !== eb) begin n_fail++; $display("FAIL cont_busy h=%0d cyc=%0d got=%b exp=%b", h, c, busy, eb); end
                n_tests++; if (ncnt !== 32'(ec)) begin n_fail++; $display("FAIL cont_cnt h=%0d cyc=%0d got=%0d exp=%0d", h, c, ncnt, ec); end
                n_tests++; if (ncnt_s !== 4'((ec > 15) ? 15 : ec)) begin n_fail++; $display("FAIL cont_cnt_sat h=%0d cyc=%0d got=%0d exp=%0d", h, c, ncnt_s, (ec > 15) ? 15 : ec); end
            end
            start = (c == 0) || ((c <= h + NS) && ($urandom_range(0, 3) == 0));
            mode  = (c == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            step  = 1'($urandom_range(0, 1));
            abort = 1'b0;
            if (c == h)                 instr = word(1'b1);
            else if (c > 0 && c < h)    instr = word(1'b0);
            else                        instr = word($urandom_range(0, 1) == 1);
            tick();
        end
        start = 1'b0; step = 1'b0;
    endtask

    // Single-step: nsteps pulses; gap < 0 gives random spacing; optional HALT on the last step
    task automatic test_step(input int nsteps, input bit halt_last, input int gap);
        bit   sa[0:255], ev_a[0:255], eh_a[0:255], ed_a[0:255], hlt[0:255];
        int   s, p, last, done_c, sum;
        logic ev, eb;
        for (int i = 0; i < 256; i++) begin
            sa[i] = 0; ev_a[i] = 0; eh_a[i] = 0; ed_a[i] = 0; hlt[i] = 0;
        end
        s = 1 + ((gap < 0) ? $urandom_range(0, 3) : 1);
        done_c = 255;
        for (int k = 0; k < nsteps; k++) begin
            sa[s] = 1; p = s + 1; ev_a[p] = 1;
            if (halt_last && k == nsteps - 1) begin
                hlt[p] = 1;
                for (int d = 1; d < NS; d++) begin ev_a[p + d] = 1; eh_a[p + d] = 1; end
                done_c = p + NS; ed_a[done_c] = 1;
            end
            s = s + ((gap < 0) ? 2 + $urandom_range(0, 3) : gap);
        end
        last = halt_last ? done_c + 2 : s + 1;
        sum = 0;
        for (int c = 0; c <= last; c++) begin
            if (c > 0) begin
                ev = ev_a[c];
                eb = (c <= done_c);
                n_tests++; if (valid !== ev) begin n_fail++; $display("FAIL step_valid cyc=%0d got=%b exp=%b", c, valid, ev); end
                n_tests++; if (hold !== eh_a[c]) begin n_fail++; $display("FAIL step_hold cyc=%0d got=%b exp=%b", c, hold, eh_a[c]); end
                n_tests++; if (done !== ed_a[c]) begin n_fail++; $display("FAIL step_done cyc=%0d got=%b exp=%b", c, done, ed_a[c]); end
                n_tests++; if (busy !== eb) begin n_fail++; $display("FAIL step_busy cyc=%0d got=%b exp=%b", c, busy, eb); end
                n_tests++; if (ncnt !== 32'(sum)) begin n_fail++; $display("FAIL step_cnt cyc=%0d got=%0d exp=%0d", c, ncnt, sum); end
                sum += int'(ev_a[c]);
            end
            start = (c == 0);
            mode  = 1'b1;
            abort = !halt_last && (c == last);
            step  = sa[c] | (1'($urandom_range(0, 1)) & ((c == 0) || ev_a[c] || (c >= done_c)));
            if (hlt[c])                   instr = word(1'b1);
            else if (ev_a[c] && !eh_a[c]) instr = word(1'b0);
            else                          instr = word($urandom_range(0, 1) == 1);
            tick();
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL step_end_busy got=%b exp=0", busy); end
        n_tests++; if (ncnt !== 32'(sum)) begin n_fail++; $display("FAIL step_end_cnt got=%0d exp=%0d", ncnt, sum); end
        start = 1'b0; step = 1'b0; abort = 1'b0;
    endtask

    // Abort in RUN cycle k together with HALT and a step pulse
    task automatic test_abort(input int k);
        logic ev;
        int   ec;
        for (int c = 0; c <= k + NS + 2; c++) begin
            if (c > 0) begin
                ev = (c <= k);
                ec = (c - 1 < k) ? c - 1 : k;
                n_tests++; if (valid !== ev) begin n_fail++; $display("FAIL abort_valid k=%0d cyc=%0d got=%b exp=%b", k, c, valid, ev); end
                n_tests++; if (busy !== ev) begin n_fail++; $display("FAIL abort_busy k=%0d cyc=%0d got=%b exp=%b", k, c, busy, ev); end
                n_tests++; if (hold !== 1'b0) begin n_fail++; $display("FAIL abort_hold k=%0d cyc=%0d got=%b exp=0", k, c, hold); end
                n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done k=%0d cyc=%0d got=%b exp=0", k, c, done); end
                n_tests++; if (ncnt !== 32'(ec)) begin n_fail++; $display("FAIL abort_cnt k=%0d cyc=%0d got=%0d exp=%0d", k, c, ncnt, ec); end
            end
            start = (c == 0);
            mode  = 1'b0;
            abort = (c == k);
            step  = (c == k);
            if (c == k)               instr = word(1'b1);
            else if (c > 0 && c < k)  instr = word(1'b0);
            else                      instr = word($urandom_range(0, 1) == 1);
            tick();
        end
        abort = 1'b0; step = 1'b0; start = 1'b0;
    endtask

    // 20 RUN cycles without HALT; the 4-bit counter must stop at 15
    task automatic test_saturation();
        int ec;
        for (int c = 0; c <= 22; c++) begin
            if (c > 0) begin
                ec = (c - 1 < 20) ? c - 1 : 20;
                n_tests++; if (ncnt_s !== 4'((ec > 15) ? 15 : ec)) begin n_fail++; $display("FAIL sat_cnt cyc=%0d got=%0d exp=%0d", c, ncnt_s, (ec > 15) ? 15 : ec); end
                n_tests++; if (ncnt !== 32'(ec)) begin n_fail++; $display("FAIL sat_wide_cnt cyc=%0d got=%0d exp=%0d", c, ncnt, ec); end
                n_tests++; if (valid_s !== (c <= 20)) begin n_fail++; $display("FAIL sat_valid cyc=%0d got=%b exp=%b", c, valid_s, c <= 20); end
            end
            start = (c == 0);
            mode  = 1'b0;
            abort = (c == 20);
            instr = word(1'b0);
            tick();
        end
        abort = 1'b0; start = 1'b0;
    endtask

    // Asynchronous reset in the middle of the drain
    task automatic test_reset_in_drain();
        start = 1'b1; mode = 1'b0; instr = word(1'b0);
        tick();
        start = 1'b0;
        tick();
        instr = word(1'b1);
        tick();
        instr = word(1'b0);
        tick();
        n_tests++; if (hold !== 1'b1) begin n_fail++; $display("FAIL rdrain_pre_hold got=%b exp=1", hold); end
        n_tests++; if (ncnt !== 32'd3) begin n_fail++; $display("FAIL rdrain_pre_cnt got=%0d exp=3", ncnt); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rdrain_valid got=%b exp=0", valid); end
        n_tests++; if (hold !== 1'b0) begin n_fail++; $display("FAIL rdrain_hold got=%b exp=0", hold); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rdrain_busy got=%b exp=0", busy); end
        n_tests++; if (ncnt !== 32'd0) begin n_fail++; $display("FAIL rdrain_cnt got=%0d exp=0", ncnt); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rdrain_post_busy got=%b exp=0", busy); end
    endtask

`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
    // Breakpoint at PC 8 reached in RUN cycle 3, then one manual step
    task automatic test_breakpoint();
        logic ev;
        int   ec;
        bp_en = 1'b1; bp_pc = 32'h0000_0008;
        for (int c = 0; c <= 9; c++) begin
            if (c > 0) begin
                ev = (c <= 3) || (c == 7);
                ec = (c <= 3) ? c - 1 : ((c <= 7) ? 3 : 4);
                n_tests++; if (valid !== ev) begin n_fail++; $display("FAIL bp_valid cyc=%0d got=%b exp=%b", c, valid, ev); end
                n_tests++; if (brk !== (c == 4)) begin n_fail++; $display("FAIL bp_break cyc=%0d got=%b exp=%b", c, brk, c == 4); end
                n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy cyc=%0d got=%b exp=1", c, busy); end
                n_tests++; if (ncnt !== 32'(ec)) begin n_fail++; $display("FAIL bp_cnt cyc=%0d got=%0d exp=%0d", c, ncnt, ec); end
            end
            start    = (c == 0);
            mode     = 1'b0;
            fetch_pc = (c == 0) ? 32'd8 : 32'((c - 1) * 4);
            step     = (c == 6);
            abort    = (c == 9);
            instr    = word(1'b0);
            tick();
        end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_end_busy got=%b exp=0", busy); end
        abort = 1'b0; step = 1'b0; start = 1'b0; bp_en = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_continuous(4);
        for (int i = 0; i < 3; i++) test_continuous($urandom_range(1, 12));
        test_step(3, 1'b0, 4);
        test_step(3, 1'b1, -1);
        test_step($urandom_range(1, 5), 1'b1, -1);
        test_step($urandom_range(2, 5), 1'b0, -1);
        test_abort(5);
        test_abort($urandom_range(1, 9));
        test_saturation();
        test_reset_in_drain();
        test_continuous(3);
`ifdef PIPELINE_RUN_CTRL_BREAKPOINT_EN
        test_breakpoint();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
